// File: rtl/tinyalu_pkg.sv
// rtl/tinyalu_pkg.sv - shared opcode/state types and limits for tinyalu_param
package tinyalu_pkg;

  localparam int MAX_WIDTH      = 32;
  localparam int MAX_MUL_CYCLES = 8;
  localparam int CNT_W          = 3;

  typedef enum logic [2:0] {
    no_op  = 3'd0,
    add_op = 3'd1,
    and_op = 3'd2,
    xor_op = 3'd3,
    mul_op = 3'd4,
    sub_op = 3'd5,
    rsv_op = 3'd6,
    rst_op = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_exec = 2'd1,
    st_mul  = 2'd2,
    st_done = 2'd3
  } state_t;

endpackage

// File: rtl/tinyalu_mult.sv
// rtl/tinyalu_mult.sv - pipelined unsigned multiplier; the caller's result register is the final stage
module tinyalu_mult
  import tinyalu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0] pipe [MUL_CYCLES];

  // Stage 0 reloads while enabled; the loaded product still walks to the end untouched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MUL_CYCLES; i++) pipe[i] <= '0;
    end else if (en) begin
      pipe[0] <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      for (int i = 1; i < MUL_CYCLES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign product = pipe[MUL_CYCLES-1];

endmodule

// File: rtl/tinyalu_param.sv
// rtl/tinyalu_param.sv - multi-cycle ALU with edge-triggered start, busy and configurable mul latency
// Optional subtract (op 5) is built only when TINYALU_SUB_EN is defined.
module tinyalu_param
  import tinyalu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           op,
  input  logic                 start,
  output logic                 done,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   result
);

  generate
    if (WIDTH < 4 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("tinyalu_param: WIDTH must be 4..32");
    end
    if (MUL_CYCLES < 1 || MUL_CYCLES > MAX_MUL_CYCLES) begin : g_bad_mul
      $error("tinyalu_param: MUL_CYCLES must be 1..8");
    end
  endgenerate

  state_t               state;
  logic                 start_q;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  op_t                  op_q;
  op_t                  op_in;
  logic                 accept;
  logic                 mul_en;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   exec_val;
  logic [2*WIDTH-1:0]   product;

  assign op_in  = op_t'(op);
  assign accept = start && !start_q && (state == st_idle);
  assign mul_en = (accept && op_in == mul_op) || (state == st_mul);
  assign sum    = {1'b0, a_q} + {1'b0, b_q};

  tinyalu_mult #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mult (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (mul_en),
    .a       (A),
    .b       (B),
    .product (product)
  );

`ifdef TINYALU_SUB_EN
  logic [WIDTH:0] diff;
  // Top bit of the widened difference is the borrow
  assign diff = {1'b0, a_q} - {1'b0, b_q};
`endif

  always_comb begin
    exec_val = '0;
    case (op_q)
      add_op:  exec_val = {{(WIDTH-1){1'b0}}, sum};
      and_op:  exec_val = {{WIDTH{1'b0}}, a_q & b_q};
      xor_op:  exec_val = {{WIDTH{1'b0}}, a_q ^ b_q};
`ifdef TINYALU_SUB_EN
      sub_op:  exec_val = {{(WIDTH-1){1'b0}}, diff};
`endif
      default: exec_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= st_idle;
      start_q <= 1'b0;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= no_op;
      result  <= '0;
    end else begin
      start_q <= start;
      case (state)
        st_idle: begin
          if (accept) begin
            case (op_in)
              add_op, and_op, xor_op: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= op_in;
                state <= st_exec;
              end
`ifdef TINYALU_SUB_EN
              sub_op: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= op_in;
                state <= st_exec;
              end
`endif
              mul_op: begin
                cnt   <= CNT_W'(MUL_CYCLES - 1);
                state <= st_mul;
              end
              rst_op:  result <= '0;
              default: ;
            endcase
          end
        end
        st_exec: begin
          result <= exec_val;
          state  <= st_done;
        end
        st_mul: begin
          if (cnt == '0) begin
            result <= product;
            state  <= st_done;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        st_done: state <= st_idle;
        default: state <= st_idle;
      endcase
    end
  end

  assign done = (state == st_done);
  assign busy = (state != st_idle);

endmodule
